// File: rtl/pot_pkg.sv
// Shared types and sizing helpers for the power-of-two weight encoders
// and the PoT shift multipliers that consume their codes.
package pot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } pot_enc_state_e;

    // Largest exponent that fits in the code once the sign bit is taken.
    function automatic int pot_exp_max(input int weight_bit_width);
        return (1 << (weight_bit_width - 1)) - 1;
    endfunction

    function automatic int pot_code_width(input int exp_max);
        return $clog2(exp_max + 1) + 1;
    endfunction

endpackage

// File: rtl/pot_round_clamp.sv
// Turns a leading-one position plus its round bit into a signed PoT code,
// clamping exponents that do not fit in the code.
module pot_round_clamp
    import pot_pkg::*;
#(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int VALUE_BIT_WIDTH  = 16
) (
    input  logic [$clog2(VALUE_BIT_WIDTH)-1:0] p,
    input  logic                               r,
    input  logic                               zero,
    input  logic                               sign,
    output logic [WEIGHT_BIT_WIDTH-1:0]        out_code,
    output logic                               out_sat,
    output logic                               out_zero
);

    localparam int EXP_W   = WEIGHT_BIT_WIDTH - 1;
    localparam int RAW_W   = $clog2(VALUE_BIT_WIDTH) + 1;
    localparam int EXP_MAX = pot_exp_max(WEIGHT_BIT_WIDTH);

    logic [RAW_W-1:0] exp_raw;
    logic             sat;

    // Rounding up to the next power of two is simply p + 1 when r is set.
    assign exp_raw = {1'b0, p} + {{(RAW_W-1){1'b0}}, r};
    assign sat     = int'(exp_raw) > EXP_MAX;

    always_comb begin
        out_code = '0;
        out_sat  = 1'b0;
        out_zero = 1'b0;
        if (zero) begin
            out_zero = 1'b1;
        end else begin
            out_sat  = sat;
            out_code = {sign, sat ? EXP_W'(EXP_MAX) : EXP_W'(exp_raw)};
        end
    end

endmodule

// File: rtl/pot_weight_encoder.sv
// Iterative signed-weight to power-of-two code encoder: one magnitude bit
// is examined per cycle, scanning down from the MSB to the leading one.
module pot_weight_encoder
    import pot_pkg::*;
#(
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int VALUE_BIT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [VALUE_BIT_WIDTH-1:0]  in_value,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WEIGHT_BIT_WIDTH-1:0] out_code,
    output logic                        out_zero,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int N     = VALUE_BIT_WIDTH;
    localparam int IDX_W = $clog2(N);

    pot_enc_state_e              state, state_next;
    logic [N-1:0]                mag, mag_next;
    logic [IDX_W-1:0]            idx, idx_next;
    logic                        sign, sign_next;
    logic [WEIGHT_BIT_WIDTH-1:0] code_q, code_next;
    logic                        zero_q, zero_next;
    logic                        sat_q, sat_next;

    logic [WEIGHT_BIT_WIDTH-1:0] rc_code;
    logic                        rc_sat;
    logic                        rc_zero;
    logic                        rc_r;

    // The bit just below the leading one decides rounding; there is none at idx 0.
    assign rc_r = (idx != '0) & mag[N-2];

    pot_round_clamp #(
        .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
        .VALUE_BIT_WIDTH (VALUE_BIT_WIDTH)
    ) u_round_clamp (
        .p       (idx),
        .r       (rc_r),
        .zero    (~mag[N-1]),
        .sign    (sign),
        .out_code(rc_code),
        .out_sat (rc_sat),
        .out_zero(rc_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mag    <= '0;
            idx    <= '0;
            sign   <= 1'b0;
            code_q <= '0;
            zero_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            state  <= state_next;
            mag    <= mag_next;
            idx    <= idx_next;
            sign   <= sign_next;
            code_q <= code_next;
            zero_q <= zero_next;
            sat_q  <= sat_next;
        end
    end

    always_comb begin
        state_next = state;
        mag_next   = mag;
        idx_next   = idx;
        sign_next  = sign;
        code_next  = code_q;
        zero_next  = zero_q;
        sat_next   = sat_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_next  = in_value[N-1];
                    // Negating the most negative value wraps to 2^(N-1), which is the true magnitude.
                    mag_next   = in_value[N-1] ? (~in_value + N'(1)) : in_value;
                    idx_next   = IDX_W'(N - 1);
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (mag[N-1] || (idx == '0)) begin
                    code_next  = rc_code;
                    zero_next  = rc_zero;
                    sat_next   = rc_sat;
                    state_next = OUT;
                end else begin
                    mag_next = mag << 1;
                    idx_next = idx - IDX_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_code  = code_q;
    assign out_zero  = zero_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_pot_weight_encoder.sv
// Directed bench for pot_weight_encoder: literal expectations per transaction
// plus a cycle-by-cycle comparison against an arithmetic rounding model.
module tb_pot_weight_encoder;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_value = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_code;
    logic         out_zero;
    logic         out_sat;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    pot_weight_encoder #(
        .WEIGHT_BIT_WIDTH(W),
        .VALUE_BIT_WIDTH (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_code (out_code),
        .out_zero (out_zero),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Nearest power of two in the linear domain, ties upward, exponent clamped.
    task automatic model_encode(input logic [N-1:0] v, output logic [W-1:0] code,
                                output logic zero, output logic sat, output int lat);
        int m;
        int p;
        int e;
        logic [W-2:0] ef;
        m = v[N-1] ? ((1 << N) - int'(v)) : int'(v);
        code = '0;
        zero = 1'b0;
        sat  = 1'b0;
        if (m == 0) begin
            zero = 1'b1;
            lat  = N;
        end else begin
            p = 0;
            for (int i = 0; i < N; i++) if (m >= (1 << i)) p = i;
            e = (2 * m >= 3 * (1 << p)) ? p + 1 : p;
            if (e > (1 << (W - 1)) - 1) begin
                sat = 1'b1;
                e = (1 << (W - 1)) - 1;
            end
            ef   = e[W-2:0];
            code = {v[N-1], ef};
            lat  = N - p;
        end
    endtask

    logic         exp_busy = 1'b0;
    logic         exp_ov;
    int           acc_edge = 0;
    logic [W-1:0] m_code = '0;
    logic         m_zero = 1'b0;
    logic         m_sat = 1'b0;
    int           m_lat = 0;

    // Compare process: tracks the handshakes and checks every output each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_busy = 1'b0;
            check("reset in_ready", 32'(in_ready), 32'd1);
            check("reset out_valid", 32'(out_valid), 32'd0);
            check("reset out_code", 32'(out_code), 32'd0);
            check("reset out_zero", 32'(out_zero), 32'd0);
            check("reset out_sat", 32'(out_sat), 32'd0);
        end else begin
            exp_ov = exp_busy && (cycle >= acc_edge + m_lat);
            check("mon in_ready", 32'(in_ready), 32'(!exp_busy));
            check("mon out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("mon out_code", 32'(out_code), 32'(m_code));
                check("mon out_zero", 32'(out_zero), 32'(m_zero));
                check("mon out_sat", 32'(out_sat), 32'(m_sat));
            end
            if (!exp_busy && in_valid) begin
                model_encode(in_value, m_code, m_zero, m_sat, m_lat);
                acc_edge = cycle + 1;
                exp_busy = 1'b1;
            end else if (exp_ov && out_ready) begin
                exp_busy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [N-1:0] v, output int lat, output logic ok);
        @(posedge clk);
        #1;
        in_value = v;
        in_valid = 1'b1;
        ok = 1'b0;
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("out_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic check_output(input string name, input logic [W-1:0] code, input logic zero,
                                input logic sat, input int exp_lat, input int lat, input int hold);
        check({name, " code"}, 32'(out_code), 32'(code));
        check({name, " zero"}, 32'(out_zero), 32'(zero));
        check({name, " sat"}, 32'(out_sat), 32'(sat));
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check({name, " held valid"}, 32'(out_valid), 32'd1);
            check({name, " held in_ready"}, 32'(in_ready), 32'd0);
            check({name, " held code"}, 32'(out_code), 32'(code));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " drop valid"}, 32'(out_valid), 32'd0);
        check({name, " back to idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_txn(input string name, input logic [N-1:0] v, input logic [W-1:0] code,
                           input logic zero, input logic sat, input int exp_lat, input int hold);
        int   lat;
        logic ok;
        apply_stimulus(v, lat, ok);
        if (ok) check_output(name, code, zero, sat, exp_lat, lat, hold);
    endtask

    initial begin
        logic [W-1:0] pc;
        logic         pz;
        logic         ps;
        int           pl;
        int           n;
        logic [N-1:0] b2b[4];

        // Pin the model itself against hand-worked values.
        model_encode(16'd5, pc, pz, ps, pl);
        check("model +5 code", 32'(pc), 32'd2);
        check("model +5 lat", 32'(pl), 32'd14);
        model_encode(16'h8000, pc, pz, ps, pl);
        check("model min code", 32'(pc), 32'd15);
        check("model min sat", 32'(ps), 32'd1);
        check("model min lat", 32'(pl), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_txn("pos5", 16'd5, 4'b0010, 1'b0, 1'b0, 14, 0);
        run_txn("neg12", 16'hFFF4, 4'b1100, 1'b0, 1'b0, 13, 0);
        run_txn("pos6", 16'd6, 4'b0011, 1'b0, 1'b0, 14, 0);
        run_txn("pos300", 16'd300, 4'b0111, 1'b0, 1'b1, 8, 0);
        run_txn("min", 16'h8000, 4'b1111, 1'b0, 1'b1, 1, 0);
        run_txn("zero", 16'd0, 4'b0000, 1'b1, 1'b0, 16, 0);
        run_txn("one", 16'd1, 4'b0000, 1'b0, 1'b0, 16, 0);
        run_txn("stall", 16'hFFF4, 4'b1100, 1'b0, 1'b0, 13, 5);

        // Back-to-back with in_valid held: each value is taken only from IDLE.
        b2b[0] = 16'd7;
        b2b[1] = 16'hFFFF;
        b2b[2] = 16'h4000;
        b2b[3] = 16'd3;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_value = b2b[i];
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                if (in_ready) break;
                n++;
            end
            if (n == 50) check("b2b accept timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b drained", 32'(in_ready), 32'd1);

        // Reset in the fourth SCAN cycle drops the weight at once.
        in_value = 16'd5;
        in_valid = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn("post reset", 16'd5, 4'b0010, 1'b0, 1'b0, 14, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pot_weight_encoder.md
# pot_weight_encoder

Iterative encoder that quantises a signed two's-complement weight into a power-of-two (PoT) weight code: sign bit in the MSB, exponent in the lower `WEIGHT_BIT_WIDTH-1` bits, representing `±2^exp`. It produces the codes consumed by the PoT shift multipliers in the multiplication library, and sits in the weight-loading path ahead of weight storage. Input and output use valid/ready handshakes. A multi-cycle leading-one scan keeps the area small.

## Interface
- `WEIGHT_BIT_WIDTH`, 4, PoT code width; exponent field width is `WEIGHT_BIT_WIDTH-1`, so `EXP_MAX = 2**(WEIGHT_BIT_WIDTH-1)-1`.
- `VALUE_BIT_WIDTH` (N), 16, width of the signed input weight; must be ≥ 2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_value`  in  N  signed two's-complement weight.
- `in_valid`  in  1  `in_value` is valid.
- `in_ready`  out  1  encoder can accept; high only in IDLE.
- `out_code`  out  WEIGHT_BIT_WIDTH  `{sign, exp}` PoT code.
- `out_zero`  out  1  input was 0; `out_code` is 0.
- `out_sat`  out  1  rounded exponent exceeded `EXP_MAX` and was clamped.
- `out_valid`  out  1  outputs valid.
- `out_ready`  in  1  downstream accepts.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
    - On `in_valid`: latch `sign = in_value[N-1]` and magnitude `mag = |in_value|` as an N-bit unsigned value (`-2^(N-1)` gives `0x8000` for N=16, no overflow).
    - Set `idx = N-1` and go to SCAN.
  - SCAN: each cycle, test `mag[N-1]`.
    - If set: `p = idx`; `r = mag[N-2]` if `idx > 0`, else `r = 0`. Load the outputs and go to OUT.
    - Else if `idx == 0`: zero result. Load the outputs and go to OUT.
    - Else: `mag <<= 1`, `idx -= 1`.
  - OUT: `out_valid=1`. On `out_ready`, go to IDLE.
- Rounding and clamping:
  - Round to the nearest power of two in the linear domain; ties round up.
  - `exp_raw = p + r`, computed with `$clog2(N)+1` bits.
  - If `exp_raw > EXP_MAX`: `exp = EXP_MAX` and `out_sat = 1`. Otherwise `exp = exp_raw` and `out_sat = 0`.
- Zero result: `out_code = 0`, `out_zero = 1`, `out_sat = 0`, and sign is forced to 0.
- Nonzero result: `out_code = {sign, exp}`, `out_zero = 0`.
- Outputs are registered and held stable while `out_valid && !out_ready`.
- `in_value` is ignored outside IDLE. There is no overlap between transactions.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `in_ready=1`, `out_valid=0`, `out_code=0`, `out_zero=0`, `out_sat=0`, internal registers 0.
- Input accepted at edge k. `out_valid` rises after edge k+L:
  - `L = N - p` for nonzero input (1 ≤ L ≤ N);
  - `L = N` for zero.
- `out_valid` falls at the edge where `out_ready` is seen high. `in_ready` rises at that same edge.
- Minimum issue interval is L+1 cycles with `out_ready` held high.
- `rst_n` low mid-SCAN or mid-OUT: immediate return to reset values; the in-flight weight is dropped.
- `in_valid` high during SCAN/OUT: no effect. The source must hold `in_valid` until `in_ready`.

## Structure
- Package `pot_pkg`:
  - function `pot_exp_max(int weight_bit_width)`;
  - enum `pot_enc_state_e {IDLE, SCAN, OUT}`;
  - function `pot_code_width(int exp_max)` for consumers.
- Sub-module `pot_round_clamp` (combinational):
  - inputs `p`, `r`, zero flag, sign;
  - outputs `out_code`, `out_sat`, `out_zero`.
- The sub-module is shared with any future parallel (single-cycle) encoder.
- FSM, magnitude shifter and index counter live in the top module.

## Test plan
All cases use N=16, WEIGHT_BIT_WIDTH=4.
- `in_value=+5` (p=2, r=0) → code `4'b0010`, zero=0, sat=0, `out_valid` 14 cycles after accept.
- `in_value=-12` (p=3, r=1) → code `4'b1100`, L=13. `in_value=+6` → code `4'b0011`.
- `in_value=+300` (p=8) → code `4'b0111`, sat=1, L=8. `in_value=-32768` → code `4'b1111`, sat=1, L=1.
- `in_value=0` → code `4'b0000`, zero=1, L=16. `in_value=+1` → code `4'b0000`, zero=0, L=16.
- Hold `out_ready=0` for 5 cycles after `out_valid` → outputs stable, `in_ready=0`. Then pulse `out_ready` → IDLE next edge. Back-to-back inputs with `in_valid` held high → each accepted only in IDLE, results in order.
- Assert `rst_n=0` in cycle 4 of a SCAN → `out_valid=0`, `in_ready=1` immediately. After release, a new `+5` encodes correctly.
